movem_sequencer: RTL
====================

Name: movem_sequencer

Overview:
- Sequences multi-register transfers (MOVEM-style) through the data register file, one register per bus transfer.
- Latches an 8-bit register mask and walks the set bits in priority order.
- For each set bit, drives the register-file select and write strobe, and handshakes each transfer with the bus/memory unit.
- Sits between the instruction decoder (START/MASK/DIR) and the data register file plus bus interface.

Parameters:
- REG_COUNT, 8, number of data registers covered by MASK; REG_SEL width is clog2(REG_COUNT).
- CNT_WIDTH, 4, width of the COUNT output; must hold REG_COUNT.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a sequence; sampled only in IDLE.
- MASK  input  REG_COUNT  register list; bit i selects Dn with n = i; sampled with START.
- DIR  input  1  0 = register-to-memory (read regs), 1 = memory-to-register (write regs); sampled with START.
- PREDEC  input  1  1 = walk from the highest set bit down; 0 = walk from the lowest set bit up; sampled with START.
- XFER_ACK  input  1  bus unit completed the current transfer; for DIR=1, bus data is valid on D this cycle.
- XFER_REQ  output  1  transfer request for the register on REG_SEL.
- REG_SEL  output  3  register-file select, to both read-select A and the write target.
- REG_WE  output  1  register-file write strobe (S).
- BUSY  output  1  high from the cycle after START is accepted until DONE.
- DONE  output  1  one-cycle pulse when the sequence ends.
- COUNT  output  CNT_WIDTH  transfers completed in the current or last sequence.

Behaviour:
- Reset values: XFER_REQ=0, REG_SEL=0, REG_WE=0, BUSY=0, DONE=0, COUNT=0, state=IDLE, internal mask=0. Reset has priority over every other input, including mid-sequence; there is no partial write after reset.
- States: IDLE, XFER, FIN.
- IDLE, START=1:
  - Latch MASK, DIR and PREDEC; clear COUNT.
  - If MASK≠0: go to XFER.
  - If MASK=0: go to FIN with no transfers.
  - START while not in IDLE is ignored.
- XFER:
  - BUSY=1, XFER_REQ=1.
  - REG_SEL = index of the lowest set bit of the latched mask (PREDEC=0) or the highest set bit (PREDEC=1). REG_SEL is combinational from the latched mask and stays stable while XFER_REQ is high and ACK is low.
  - XFER_ACK=0: hold all outputs.
  - XFER_ACK=1:
    - Clear the selected mask bit and increment COUNT (visible next cycle).
    - If DIR=1, REG_WE=1 in this same cycle only; REG_WE is combinational: XFER & ACK & DIR.
    - If the cleared bit was the last set bit, go to FIN; otherwise stay in XFER with the next REG_SEL the following cycle.
- Timing: START to first XFER_REQ is 1 cycle. Back-to-back ACKs give one transfer per cycle. XFER_ACK outside XFER is ignored.
- FIN:
  - DONE=1 and BUSY=1 for one cycle.
  - XFER_REQ=0.
  - Return to IDLE.
  - COUNT holds until the next accepted START.
- Boundaries:
  - MASK=0xFF: 8 transfers, COUNT=8.
  - A single-bit mask gives one transfer.
  - PREDEC has no effect on which registers are transferred, only on order.
  - START asserted in the same cycle DONE pulses is ignored; it is accepted on the next IDLE cycle.

Optional Feature:
- Macro: MOVEM_ABORT_EN.
- When defined:
  - Adds input ABORT (1 bit) and output ABORTED (1 bit, reset 0).
  - ABORT=1 in XFER: the sequence terminates. If XFER_ACK is also high, that transfer completes, including REG_WE and the COUNT increment, before termination.
  - The next cycle is IDLE with ABORTED=1 pulsed for one cycle and DONE not pulsed.
  - ABORT in IDLE or FIN is ignored.
- When not defined: no ABORT/ABORTED ports; the sequence always runs to FIN.

Test Plan:
- Reset mid-sequence: START, MASK=0x0F, DIR=1, then RESET high after 2 ACKs -> next cycle all outputs 0, state IDLE, no further REG_WE.
- Ascending write: START, MASK=0x29, DIR=1, PREDEC=0, ACK held high -> REG_SEL 0,3,5 on consecutive cycles; REG_WE high each cycle; DONE 1 cycle later; COUNT=3.
- Descending read with stalls: MASK=0x81, DIR=0, PREDEC=1, ACK after 3 wait cycles each -> REG_SEL=7 held 4 cycles, then REG_SEL=0; REG_WE never high; COUNT=2.
- Empty mask: START, MASK=0x00 -> no XFER_REQ; DONE pulses 1 cycle after START; COUNT=0.
- Full mask plus ignored START: MASK=0xFF, DIR=1, START re-asserted mid-sequence -> exactly 8 transfers, REG_SEL 0..7, COUNT=8, single DONE.
- Abort (MOVEM_ABORT_EN defined): MASK=0x0F, ABORT together with the 2nd ACK -> 2 REG_WE pulses, ABORTED pulse, no DONE, COUNT=2.

Source files
------------

// File: rtl/movem_sequencer_if.sv
// ---------------------------------------------------------------------------
// movem_sequencer_if
//   Groups the decoder-side request signals and the register-file / bus-unit
//   handshake of the MOVEM sequencer into one bundle.
//
//   Signals:
//     start, mask, dir, predec  decoder request (sampled with start in IDLE)
//     xfer_ack                  bus unit finished the current transfer
//     xfer_req                  transfer request for the register on reg_sel
//     reg_sel                   register-file select (read and write target)
//     reg_we                    register-file write strobe
//     busy, done, count         sequence status
//     abort, aborted            only present with MOVEM_ABORT_EN defined
//
//   Modports:
//     master  decoder / bus side (drives requests and acks)
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface movem_sequencer_if #(
   parameter int REG_COUNT = 8,
   parameter int CNT_WIDTH = 4
);
   localparam int SEL_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   logic                 start;
   logic [REG_COUNT-1:0] mask;
   logic                 dir;
   logic                 predec;
   logic                 xfer_ack;
   logic                 xfer_req;
   logic [SEL_W-1:0]     reg_sel;
   logic                 reg_we;
   logic                 busy;
   logic                 done;
   logic [CNT_WIDTH-1:0] count;
`ifdef MOVEM_ABORT_EN
   logic                 abort;
   logic                 aborted;

   modport master (
      output start, mask, dir, predec, xfer_ack, abort,
      input  xfer_req, reg_sel, reg_we, busy, done, count, aborted
   );

   modport slave (
      input  start, mask, dir, predec, xfer_ack, abort,
      output xfer_req, reg_sel, reg_we, busy, done, count, aborted
   );
`else
   modport master (
      output start, mask, dir, predec, xfer_ack,
      input  xfer_req, reg_sel, reg_we, busy, done, count
   );

   modport slave (
      input  start, mask, dir, predec, xfer_ack,
      output xfer_req, reg_sel, reg_we, busy, done, count
   );
`endif
endinterface

// File: rtl/movem_sequencer.sv
// ---------------------------------------------------------------------------
// movem_sequencer
//   Walks the set bits of a latched register mask, issuing one bus transfer
//   per register. Lowest bit first normally, highest bit first when predec
//   was set with start. For memory-to-register moves (dir=1) the register
//   file write strobe fires in the cycle the bus unit acknowledges.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; overrides everything, mid-sequence too
//     bus    movem_sequencer_if.slave (request, handshake and status signals)
//
//   Optional feature (macro MOVEM_ABORT_EN):
//     bus.abort in XFER ends the sequence early (a simultaneous ack still
//     completes its transfer); bus.aborted pulses in the following IDLE cycle
//     and done is not pulsed.
// ---------------------------------------------------------------------------
module movem_sequencer #(
   parameter int REG_COUNT = 8,
   parameter int CNT_WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   movem_sequencer_if.slave bus
);
   localparam int SEL_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [REG_COUNT-1:0] mask_q, mask_d;
   logic                 dir_q, dir_d;
   logic                 predec_q, predec_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [SEL_W-1:0]     sel;
   logic                 ack_fire;
`ifdef MOVEM_ABORT_EN
   logic                 aborted_q, aborted_d;
`endif

   // Priority encoder over the latched mask. The loop direction makes the
   // last match win: ascending scan leaves the highest set bit, descending
   // scan leaves the lowest. An empty mask yields 0.
   always_comb begin
      sel = '0;
      if (predec_q) begin
         for (int i = 0; i < REG_COUNT; i++)
            if (mask_q[i]) sel = SEL_W'(i);
      end else begin
         for (int i = REG_COUNT - 1; i >= 0; i--)
            if (mask_q[i]) sel = SEL_W'(i);
      end
   end

   assign ack_fire = (state_q == XFER) && bus.xfer_ack;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // can leave one unassigned and infer a latch.
      state_d  = state_q;
      mask_d   = mask_q;
      dir_d    = dir_q;
      predec_d = predec_q;
      count_d  = count_q;
`ifdef MOVEM_ABORT_EN
      aborted_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               mask_d   = bus.mask;
               dir_d    = bus.dir;
               predec_d = bus.predec;
               count_d  = '0;
               state_d  = (bus.mask != '0) ? XFER : FIN;
            end
         end
         XFER: begin
            if (bus.xfer_ack) begin
               mask_d  = mask_q & ~({{(REG_COUNT-1){1'b0}}, 1'b1} << sel);
               count_d = count_q + CNT_WIDTH'(1);
               if (mask_d == '0) state_d = FIN;
            end
`ifdef MOVEM_ABORT_EN
            // Abort wins over both "stay" and "finish"; leftover mask bits
            // are dropped so reg_sel returns to 0 in IDLE.
            if (bus.abort) begin
               mask_d    = '0;
               state_d   = IDLE;
               aborted_d = 1'b1;
            end
`endif
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      // NOTE: reset clears all sequencing state, including the latched mask,
      // so an interrupted sequence cannot resume or write afterwards.
      if (reset) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         dir_q    <= 1'b0;
         predec_q <= 1'b0;
         count_q  <= '0;
`ifdef MOVEM_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         dir_q    <= dir_d;
         predec_q <= predec_d;
         count_q  <= count_d;
`ifdef MOVEM_ABORT_EN
         aborted_q <= aborted_d;
`endif
      end
   end

   assign bus.xfer_req = (state_q == XFER);
   assign bus.reg_sel  = sel;
   // Write strobe is combinational so the register file captures bus data in
   // the very cycle the bus unit presents it.
   assign bus.reg_we   = ack_fire && dir_q;
   assign bus.busy     = (state_q == XFER) || (state_q == FIN);
   assign bus.done     = (state_q == FIN);
   assign bus.count    = count_q;
`ifdef MOVEM_ABORT_EN
   assign bus.aborted  = aborted_q;
`endif

endmodule
